// File: rtl/traffic_phase_scheduler.sv
// Purpose : two-street intersection phase scheduler (A green, B green, exclusive pedestrian walk)
// Latency : a phase decision made at a rising edge shows on the outputs in the cycle after that edge
// Backpressure: none; the demand inputs are sampled every cycle and a pedestrian request is latched until served
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   Ta, Tb   traffic present on street A / street B
//   ped_req  pedestrian button, level or pulse
//   LA, LB   light codes: 00 green, 01 yellow, 10 red
//   walk     pedestrian walk lamp
//   ped_ack  one-cycle pulse on the first walk cycle
//   phase    current phase: 0 AG, 1 AY, 2 ALLRED, 3 WALK, 4 BG, 5 BY
module traffic_phase_scheduler #(
    parameter int GREEN_MIN   = 6,
    parameter int GREEN_MAX   = 20,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int WALK_TIME   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    output logic [1:0] LA,
    output logic [1:0] LB,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_AG     = 3'd0,
        S_AY     = 3'd1,
        S_ALLRED = 3'd2,
        S_WALK   = 3'd3,
        S_BG     = 3'd4,
        S_BY     = 3'd5
    } state_t;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    // Counter wide enough for the longest timed interval.
    localparam int CW = $clog2(GREEN_MAX + YELLOW_TIME + ALLRED_TIME + WALK_TIME + 1);

    localparam logic [CW-1:0] C_GMIN = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] C_GMAX = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] C_YEL  = CW'(YELLOW_TIME - 1);
    localparam logic [CW-1:0] C_AR   = CW'(ALLRED_TIME - 1);
    localparam logic [CW-1:0] C_WALK = CW'(WALK_TIME - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_ped_pending;
    logic            r_last_b;      // 0: street A was the last green, 1: street B
    logic [1:0]      r_la;
    logic [1:0]      r_lb;
    logic            r_walk;
    logic            r_ped_ack;
    logic [2:0]      r_phase;

    state_t          w_nxt;
    logic            w_min_ok;
    logic            w_max_ok;
    state_t          w_after_clear;

    // Next-state decision from registered state, counter and latched demand.
    always_comb begin
        w_nxt         = r_state;
        w_min_ok      = (r_cnt >= C_GMIN);
        w_max_ok      = (r_cnt >= C_GMAX);
        // After a clearance or walk, serve the street that was not green before.
        w_after_clear = r_last_b ? S_AG : S_BG;
        case (r_state)
            S_AG: begin
                if (w_min_ok && (Tb || r_ped_pending) && (!Ta || w_max_ok)) begin
                    w_nxt = S_AY;
                end
            end
            S_AY: begin
                if (r_cnt == C_YEL) begin
                    w_nxt = S_ALLRED;
                end
            end
            S_ALLRED: begin
                if (r_cnt == C_AR) begin
                    w_nxt = r_ped_pending ? S_WALK : w_after_clear;
                end
            end
            S_WALK: begin
                if (r_cnt == C_WALK) begin
                    w_nxt = w_after_clear;
                end
            end
            S_BG: begin
                if (w_min_ok && (Ta || r_ped_pending) && (!Tb || w_max_ok)) begin
                    w_nxt = S_BY;
                end
            end
            S_BY: begin
                if (r_cnt == C_YEL) begin
                    w_nxt = S_ALLRED;
                end
            end
            default: w_nxt = S_AG;  // illegal codes recover to AG
        endcase
    end

    // State, dwell counter, demand latch and outputs. Outputs are registered
    // from the next state so they line up with the state register itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_AG;
            r_cnt         <= '0;
            r_ped_pending <= 1'b0;
            r_last_b      <= 1'b0;
            r_la          <= L_GREEN;
            r_lb          <= L_RED;
            r_walk        <= 1'b0;
            r_ped_ack     <= 1'b0;
            r_phase       <= 3'd0;
        end else begin
            r_state <= w_nxt;

            if (w_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != C_GMAX) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (r_state == S_AG) begin
                r_last_b <= 1'b0;
            end else if (r_state == S_BG) begin
                r_last_b <= 1'b1;
            end

            // Requests are ignored during the walk so a held button cannot
            // chain walks; the latch clears on the first walk cycle.
            if (r_state == S_WALK) begin
                if (r_cnt == '0) begin
                    r_ped_pending <= 1'b0;
                end
            end else if (ped_req) begin
                r_ped_pending <= 1'b1;
            end

            r_la      <= L_RED;
            r_lb      <= L_RED;
            r_walk    <= 1'b0;
            r_ped_ack <= 1'b0;
            r_phase   <= 3'(w_nxt);
            case (w_nxt)
                S_AG:     r_la <= L_GREEN;
                S_AY:     r_la <= L_YELLOW;
                S_ALLRED: ;
                S_WALK: begin
                    r_walk    <= 1'b1;
                    r_ped_ack <= (r_state != S_WALK);
                end
                S_BG:     r_lb <= L_GREEN;
                S_BY:     r_lb <= L_YELLOW;
                default: begin
                    r_la    <= L_GREEN;
                    r_phase <= 3'd0;
                end
            endcase
        end
    end

    assign LA      = r_la;
    assign LB      = r_lb;
    assign walk    = r_walk;
    assign ped_ack = r_ped_ack;
    assign phase   = r_phase;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Purpose : testbench for traffic_phase_scheduler with a phase/elapsed-time reference model
// Latency : outputs compared at each falling edge against the model state for that cycle
// Backpressure: not applicable
module tb_traffic_phase_scheduler;

    localparam int GMIN = 6;
    localparam int GMAX = 20;
    localparam int YEL  = 3;
    localparam int AR   = 2;
    localparam int WLK  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       Ta;
    logic       Tb;
    logic       ped_req;
    logic [1:0] LA;
    logic [1:0] LB;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    int tests_run    = 0;
    int tests_failed = 0;
    int acks         = 0;

    // Reference model: phase number, cycles already spent in it, request
    // latch and which street was green last.
    int m_ph;
    int m_t;
    bit m_pend;
    bit m_last_a;

    traffic_phase_scheduler #(
        .GREEN_MIN  (GMIN),
        .GREEN_MAX  (GMAX),
        .YELLOW_TIME(YEL),
        .ALLRED_TIME(AR),
        .WALK_TIME  (WLK)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Ta     (Ta),
        .Tb     (Tb),
        .ped_req(ped_req),
        .LA     (LA),
        .LB     (LB),
        .walk   (walk),
        .ped_ack(ped_ack),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_out();
        logic [1:0] la;
        logic [1:0] lb;
        logic       w;
        logic       a;
        la = 2'b10;
        lb = 2'b10;
        w  = 1'b0;
        a  = 1'b0;
        case (m_ph)
            0: la = 2'b00;
            1: la = 2'b01;
            3: begin
                w = 1'b1;
                a = (m_t == 0);
            end
            4: lb = 2'b00;
            5: lb = 2'b01;
            default: ;
        endcase
        return {la, lb, w, a, 3'(m_ph)};
    endfunction

    task automatic model_reset();
        m_ph     = 0;
        m_t      = 0;
        m_pend   = 1'b0;
        m_last_a = 1'b1;
    endtask

    task automatic model_step(input logic ta, input logic tb, input logic pr);
        int nxt;
        int spent;
        nxt   = m_ph;
        spent = m_t + 1;  // cycles spent in the phase including this one
        case (m_ph)
            0: if (spent >= GMIN && (tb || m_pend) && (!ta || spent >= GMAX)) nxt = 1;
            1: if (spent == YEL) nxt = 2;
            2: if (spent == AR) nxt = m_pend ? 3 : (m_last_a ? 4 : 0);
            3: if (spent == WLK) nxt = m_last_a ? 4 : 0;
            4: if (spent >= GMIN && (ta || m_pend) && (!tb || spent >= GMAX)) nxt = 5;
            5: if (spent == YEL) nxt = 2;
            default: nxt = 0;
        endcase
        if (m_ph == 0) m_last_a = 1'b1;
        if (m_ph == 4) m_last_a = 1'b0;
        if (m_ph == 3) begin
            if (m_t == 0) m_pend = 1'b0;
        end else if (pr) begin
            m_pend = 1'b1;
        end
        m_t  = (nxt == m_ph) ? m_t + 1 : 0;
        m_ph = nxt;
    endtask

    // One cycle: compare the current outputs, apply the next inputs, advance
    // the model to where the DUT will be after the coming rising edge.
    task automatic cyc(input string tag, input logic ta, input logic tb, input logic pr, input logic rst);
        chk(tag, {LA, LB, walk, ped_ack, phase}, model_out());
        if (ped_ack === 1'b1) acks++;
        Ta      = ta;
        Tb      = tb;
        ped_req = pr;
        reset   = rst;
        if (!rst) model_reset();
        else      model_step(ta, tb, pr);
        @(negedge clk);
    endtask

    task automatic restart();
        cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset   = 1'b0;
        Ta      = 1'b1;
        Tb      = 1'b0;
        ped_req = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset hold, then A-only traffic: AG forever.
        for (int k = 0; k < 3; k++) cyc("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_outputs", {LA, LB, walk, ped_ack, phase}, 9'b00_10_0_0_000);
        for (int k = 0; k < 50; k++) cyc("idle_a", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("idle_a_phase", 9'(phase), 9'd0);

        // B-only traffic: minimum green then hand over to B.
        restart();
        for (int k = 0; k < 16; k++) begin
            if (k == 5)  chk("t2_ag_last", 9'(phase), 9'd0);
            if (k == 6)  chk("t2_ay_la", 9'(LA), 9'd1);
            if (k == 9)  chk("t2_allred", {LA, LB, walk, ped_ack, phase}, 9'b10_10_0_0_010);
            if (k == 11) chk("t2_bg", {LA, LB, walk, ped_ack, phase}, 9'b10_00_0_0_100);
            cyc("t2", 1'b0, 1'b1, 1'b0, 1'b1);
        end

        // Both streets busy: max green each side, period 50.
        restart();
        for (int k = 0; k < 110; k++) begin
            if (k == 19)  chk("t3_ag_end", 9'(phase), 9'd0);
            if (k == 20)  chk("t3_ay", 9'(phase), 9'd1);
            if (k == 25)  chk("t3_bg", 9'(phase), 9'd4);
            if (k == 45)  chk("t3_by", 9'(phase), 9'd5);
            if (k == 50)  chk("t3_ag_again", 9'(phase), 9'd0);
            if (k == 100) chk("t3_ag_third", 9'(phase), 9'd0);
            cyc("t3", 1'b1, 1'b1, 1'b0, 1'b1);
        end

        // Pedestrian pulse while A is busy: walk at 25..29, BG at 30.
        restart();
        acks = 0;
        for (int k = 0; k < 36; k++) begin
            if (k == 24) chk("t4_allred", 9'(phase), 9'd2);
            if (k == 25) chk("t4_walk_first", {7'd0, walk, ped_ack}, 9'b11);
            if (k == 26) chk("t4_walk_second", {7'd0, walk, ped_ack}, 9'b10);
            if (k == 29) chk("t4_walk_last", 9'(phase), 9'd3);
            if (k == 30) chk("t4_bg", {LA, LB, walk, ped_ack, phase}, 9'b10_00_0_0_100);
            cyc("t4", 1'b1, 1'b0, (k == 2), 1'b1);
        end
        chk("t4_ack_count", 9'(acks), 9'd1);

        // Held button: one ack per walk, next walk only after BG/BY/ALLRED.
        restart();
        acks = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 30) chk("t5_bg", 9'(phase), 9'd4);
            if (k == 36) chk("t5_by", 9'(phase), 9'd5);
            if (k == 41) begin
                chk("t5_acks_before", 9'(acks), 9'd1);
                chk("t5_second_ack", 9'(ped_ack), 9'd1);
            end
            cyc("t5", 1'b1, 1'b0, 1'b1, 1'b1);
        end

        // Asynchronous reset mid-AY with a request pending.
        restart();
        for (int k = 0; k < 7; k++) cyc("t6", 1'b0, 1'b1, (k == 1), 1'b1);
        chk("t6_in_ay", 9'(phase), 9'd1);
        #2 reset = 1'b0;
        #1 chk("t6_async_ay", {LA, LB, walk, ped_ack, phase}, 9'b00_10_0_0_000);
        model_reset();
        @(negedge clk);
        acks = 0;
        for (int k = 0; k < 40; k++) cyc("t6_post", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6_no_ack", 9'(acks), 9'd0);
        chk("t6_stays_ag", 9'(phase), 9'd0);

        // Asynchronous reset mid-WALK.
        restart();
        for (int k = 0; k < 27; k++) cyc("t6w", 1'b1, 1'b0, (k == 2), 1'b1);
        chk("t6w_in_walk", 9'(phase), 9'd3);
        #2 reset = 1'b0;
        #1 chk("t6w_async", {LA, LB, walk, ped_ack, phase}, 9'b00_10_0_0_000);
        model_reset();
        @(negedge clk);
        acks = 0;
        for (int k = 0; k < 40; k++) cyc("t6w_post", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6w_no_ack", 9'(acks), 9'd0);

        // Randomised demand, button presses and occasional resets.
        restart();
        for (int k = 0; k < 3000; k++) begin
            cyc("rand",
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 199) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Moore-style phase scheduler for a two-street intersection, street A and street B. It shares the right-of-way between A traffic, B traffic and a pedestrian crossing. Each green has a minimum and maximum dwell, yellow and all-red clearance intervals are timed, and a latched pedestrian request inserts an exclusive walk phase. It drives the LA/LB light codes of the intersection datapath directly.

Parameters:
GREEN_MIN, 6, minimum green dwell in cycles (>=1)
GREEN_MAX, 20, maximum green dwell in cycles when the other side has demand (>=GREEN_MIN)
YELLOW_TIME, 3, yellow duration in cycles (>=1)
ALLRED_TIME, 2, all-red clearance in cycles (>=1)
WALK_TIME, 5, pedestrian walk duration in cycles (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
Ta  in  1  traffic present on street A
Tb  in  1  traffic present on street B
ped_req  in  1  pedestrian button, level or pulse, sampled each cycle
LA  out  2  street A light: 00 green, 01 yellow, 10 red
LB  out  2  street B light, same encoding
walk  out  1  pedestrian walk lamp
ped_ack  out  1  one-cycle pulse on the first WALK cycle
phase  out  3  current state: 0 AG, 1 AY, 2 ALLRED, 3 WALK, 4 BG, 5 BY

Behaviour:
- Clocking and reset: one clock domain. reset=0 asynchronously forces the following, regardless of clock:
  - state=AG, cnt=0, ped_pending=0, last_green=A
  - LA=00, LB=10, walk=0, ped_ack=0, phase=0
- Outputs are decoded from the state register only (Moore), with no input-to-output combinational path.
- Dwell counter cnt:
  - Cleared to 0 on every state change.
  - Increments each cycle while in a state.
  - Saturates at GREEN_MAX-1.
- AG:
  - LA=00, LB=10, last_green<=A.
  - Exits to AY when cnt>=GREEN_MIN-1 and (Tb|ped_pending) and (!Ta | cnt>=GREEN_MAX-1).
  - With no B or pedestrian demand it stays indefinitely.
- AY: LA=01, LB=10. Lasts exactly YELLOW_TIME cycles (exits at cnt==YELLOW_TIME-1) to ALLRED.
- ALLRED:
  - LA=LB=10, for exactly ALLRED_TIME cycles.
  - Then goes to WALK if ped_pending.
  - Otherwise goes to BG if last_green==A, else AG.
- WALK:
  - LA=LB=10, walk=1, for exactly WALK_TIME cycles.
  - ped_ack=1 on the first WALK cycle only, and ped_pending clears on that cycle.
  - Exits to BG if last_green==A, else AG. The street that was not green before the walk is always served next.
- BG / BY: mirror of AG / AY with Ta and Tb swapped, LB driving the green/yellow code, and last_green<=B.
- Pedestrian latch:
  - ped_req=1 in any state other than WALK sets ped_pending.
  - ped_req during WALK is ignored, so a held button causes no back-to-back walk.
  - Requests made during yellow or all-red are honoured at the next ALLRED exit if they are latched before it.
- Exactly one of LA/LB is non-red outside ALLRED/WALK. Both are never green or yellow together.
- Timing: inputs are sampled at the rising edge where the exit condition is evaluated. The new state is visible in the cycle after that edge.
- Reset mid-operation (any state, any cnt) returns to the reset values immediately. No partial phase is resumed.
- Illegal state codes 6 and 7 return to AG on the next edge with the reset output values.

Test Plan:
1. Hold reset=0 for 3 cycles, then Ta=1, Tb=0, ped_req=0 for 50 cycles -> during reset LA=00, LB=10, walk=0, phase=0; after release the block stays in AG (phase=0) for all 50 cycles.
2. Release reset with Ta=0, Tb=1 -> AG for cycles 0-5, AY (LA=01) for cycles 6-8, ALLRED for 9-10, then BG (LB=00, LA=10, phase=4) from cycle 11.
3. Ta=Tb=1 continuously -> each green lasts exactly 20 cycles. The sequence AG20, AY3, ALLRED2, BG20, BY3, ALLRED2 repeats with a period of 50 cycles.
4. Ta=1, Tb=0, ped_req pulse at cycle 2 -> AG for 20 cycles (forced by GREEN_MAX), AY3, ALLRED2, then WALK for cycles 25-29 with walk=1 and ped_ack=1 at cycle 25 only, then BG from cycle 30.
5. Hold ped_req=1 throughout case 4 -> exactly one ped_ack. ped_pending re-sets only after WALK exits, so the next walk follows the BG/BY/ALLRED sequence and does not occur immediately.
6. Assert reset=0 asynchronously mid-AY or mid-WALK, between clock edges -> LA=00, LB=10, walk=0, phase=0 immediately; the pending request is cleared and no ped_ack occurs after release.
